riscv_trace_buffer: RTL and testbench

//   Consumer end of the processor's debug/observation outputs. Captures one {PC, Instruction}

---
 rtl/riscv_trace_buffer.sv | 187 ++++++++++++++++++
 tb/tb_riscv_trace_buffer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_trace_buffer.sv
// ---------------------------------------------------------------------------
// riscv_trace_buffer
//   Captures one {PC, Instruction} record per traced core cycle into a record
//   FIFO and streams each record to a host as three 32-bit words over a
//   valid/ready port: PC[31:0], PC[63:32], Instruction (last word flagged).
//
// Parameters
//   DEPTH   record FIFO depth (power of two, >= 2)
//   DROP_W  width of the saturating dropped-record counter
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous active-low reset
//   trace_en     global capture enable
//   trace_valid  core presents a record this cycle
//   trace_pc     64-bit PC of the traced instruction
//   trace_instr  32-bit instruction word
//   clear        synchronous flush (FIFO, drop counter, serialiser)
//   out_valid    out_data carries a valid word
//   out_ready    host accepts the word when out_valid & out_ready
//   out_data     serialised 32-bit word
//   out_last     high on the final word of a record
//   level        records held in the FIFO (excludes record being sent)
//   full         level == DEPTH
//   drop_count   records lost to a full FIFO, saturating
// ---------------------------------------------------------------------------
module riscv_trace_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_en,
    input  logic                     trace_valid,
    input  logic [63:0]              trace_pc,
    input  logic [31:0]              trace_instr,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic [DROP_W-1:0]        drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_W0,
        S_W1,
        S_W2
    } state_e;

    state_e            state_q, state_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [95:0]       mem_q [DEPTH];
    logic [95:0]       hold_q, hold_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [AW:0]       level_w;
    logic              full_w;
    logic              empty_w;
    logic              pop;
    logic              req;
    logic              push;
    logic              drop_inc;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign level_w = wr_ptr_q - rd_ptr_q;
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty_w) begin
                    pop     = 1'b1;
                    state_d = S_W0;
                end
            end
            S_W0: begin
                if (out_ready) state_d = S_W1;
            end
            S_W1: begin
                if (out_ready) state_d = S_W2;
            end
            S_W2: begin
                if (out_ready) begin
                    // Reload on the same edge so records stream without a bubble.
                    if (!empty_w) begin
                        pop     = 1'b1;
                        state_d = S_W0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (clear) begin
            state_d = S_IDLE;
            pop     = 1'b0;
        end
    end

    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        unique case (state_q)
            S_W0:    out_data = hold_q[63:32];
            S_W1:    out_data = hold_q[95:64];
            S_W2: begin
                out_data = hold_q[31:0];
                out_last = 1'b1;
            end
            default: out_data = '0;
        endcase
    end

    assign out_valid = (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // FIFO bookkeeping and drop counter
    // ------------------------------------------------------------------
    assign req = trace_en & trace_valid;
    // A pop on the same edge frees the slot, so a push at full still lands.
    assign push     = req & (~full_w | pop) & ~clear;
    assign drop_inc = req & full_w & ~pop & ~clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        hold_d   = pop ? mem_q[rd_ptr_q[AW-1:0]] : hold_q;
        drop_d   = drop_q;
        if (drop_inc && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            drop_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hold_q   <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            hold_q   <= hold_d;
            drop_q   <= drop_d;
        end
    end

    // Storage has no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {trace_pc, trace_instr};
        end
    end

    assign level      = level_w;
    assign full       = full_w;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
module tb_riscv_trace_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        trace_en = 1'b0;
    logic        trace_valid = 1'b0;
    logic [63:0] trace_pc = '0;
    logic [31:0] trace_instr = '0;
    logic        clear = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic [4:0]  level;
    logic        full;
    logic [15:0] drop_count;

    int vectors = 0;
    int miscompares = 0;

    riscv_trace_buffer #(.DEPTH(16), .DROP_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .trace_en    (trace_en),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_instr (trace_instr),
        .clear       (clear),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .level       (level),
        .full        (full),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        trace_en    = 1'b1;
        trace_valid = 1'b1;
        trace_pc    = 64'h0000_0000_0000_1234;
        trace_instr = 32'hDEAD_BEEF;
        out_ready   = 1'b1;
        repeat (3) tick();
        vectors++;
        if (out_valid !== 1'b0 || level !== 5'd0 || drop_count !== 16'd0 ||
            full !== 1'b0 || out_data !== 32'd0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got valid=%b level=%0d drop=%0d full=%b data=%h last=%b, required 0/0/0/0/0/0",
                     out_valid, level, drop_count, full, out_data, out_last);
        end
        trace_valid = 1'b0;
        reset = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_release: got valid=%b level=%0d, required 0/0", out_valid, level);
        end
    endtask

    task automatic test_single();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h0000_0010;
        exp_w[1] = 32'h0000_0001;
        exp_w[2] = 32'h00A2_8293;
        out_ready   = 1'b1;
        trace_valid = 1'b1;
        trace_pc    = 64'h0000_0001_0000_0010;
        trace_instr = 32'h00A2_8293;
        tick();
        trace_valid = 1'b0;
        vectors++;
        if (level !== 5'd1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_capture: got level=%0d valid=%b, required 1/0", level, out_valid);
        end
        for (int w = 0; w < 3; w++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exp_w[w] || out_last !== (w == 2)) begin
                miscompares++;
                $display("FAIL single_word%0d: got valid=%b data=%h last=%b, required 1/%h/%b",
                         w, out_valid, out_data, out_last, exp_w[w], (w == 2));
            end
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL single_end: got valid=%b last=%b, required 0/0", out_valid, out_last);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_w [6];
        exp_w[0] = 32'h0000_0020; exp_w[1] = 32'h0000_0002; exp_w[2] = 32'h1234_5678;
        exp_w[3] = 32'h0000_0030; exp_w[4] = 32'h0000_0003; exp_w[5] = 32'h8765_4321;
        out_ready   = 1'b1;
        trace_valid = 1'b1;
        trace_pc    = 64'h0000_0002_0000_0020;
        trace_instr = 32'h1234_5678;
        tick();
        trace_pc    = 64'h0000_0003_0000_0030;
        trace_instr = 32'h8765_4321;
        tick();
        trace_valid = 1'b0;
        vectors++;
        if (out_data !== exp_w[0] || level !== 5'd1) begin
            miscompares++;
            $display("FAIL bp_w0: got data=%h level=%0d, required %h/1", out_data, level, exp_w[0]);
        end
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exp_w[1] || out_last !== 1'b0 || level !== 5'd1) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got valid=%b data=%h last=%b level=%0d, required 1/%h/0/1",
                         i, out_valid, out_data, out_last, level, exp_w[1]);
            end
        end
        out_ready = 1'b1;
        for (int w = 2; w < 6; w++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exp_w[w] || out_last !== (w == 2 || w == 5)) begin
                miscompares++;
                $display("FAIL bp_word%0d: got valid=%b data=%h last=%b, required 1/%h/%b",
                         w, out_valid, out_data, out_last, exp_w[w], (w == 2 || w == 5));
            end
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            miscompares++;
            $display("FAIL bp_end: got valid=%b level=%0d, required 0/0", out_valid, level);
        end
    endtask

    // Record 0 moves into the serialiser one edge after capture, so 20 pushes
    // leave 16 queued, 1 held and 3 dropped.
    task automatic test_overflow();
        out_ready   = 1'b0;
        trace_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            trace_pc    = 64'(i * 4);
            trace_instr = 32'h1000 + 32'(i);
            tick();
        end
        trace_valid = 1'b0;
        vectors++;
        if (full !== 1'b1 || level !== 5'd16 || drop_count !== 16'd3) begin
            miscompares++;
            $display("FAIL overflow: got full=%b level=%0d drop=%0d, required 1/16/3", full, level, drop_count);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'd0 || level !== 5'd16 || drop_count !== 16'd3) begin
            miscompares++;
            $display("FAIL overflow_stall: got valid=%b data=%h level=%0d drop=%0d, required 1/0/16/3",
                     out_valid, out_data, level, drop_count);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_d;
        out_ready = 1'b1;
        tick();
        tick();
        vectors++;
        if (out_data !== 32'h0000_1000 || out_last !== 1'b1) begin
            miscompares++;
            $display("FAIL fpp_w2: got data=%h last=%b, required 00001000/1", out_data, out_last);
        end
        trace_valid = 1'b1;
        trace_pc    = 64'h0000_00AA_0000_0100;
        trace_instr = 32'hCAFE_0001;
        tick();
        trace_valid = 1'b0;
        vectors++;
        if (level !== 5'd16 || full !== 1'b1 || drop_count !== 16'd3 || out_data !== 32'd4) begin
            miscompares++;
            $display("FAIL fpp_swap: got level=%0d full=%b drop=%0d data=%h, required 16/1/3/00000004",
                     level, full, drop_count, out_data);
        end
        for (int r = 1; r <= 17; r++) begin
            for (int w = 0; w < 3; w++) begin
                if (r == 17) exp_d = (w == 0) ? 32'h100 : (w == 1) ? 32'hAA : 32'hCAFE_0001;
                else         exp_d = (w == 0) ? 32'(r * 4) : (w == 1) ? 32'd0 : 32'h1000 + 32'(r);
                vectors++;
                if (out_valid !== 1'b1 || out_data !== exp_d || out_last !== (w == 2)) begin
                    miscompares++;
                    $display("FAIL drain_r%0d_w%0d: got valid=%b data=%h last=%b, required 1/%h/%b",
                             r, w, out_valid, out_data, out_last, exp_d, (w == 2));
                end
                tick();
            end
        end
        vectors++;
        if (out_valid !== 1'b0 || level !== 5'd0 || full !== 1'b0 || drop_count !== 16'd3) begin
            miscompares++;
            $display("FAIL drain_end: got valid=%b level=%0d full=%b drop=%0d, required 0/0/0/3",
                     out_valid, level, full, drop_count);
        end
    endtask

    task automatic test_clear();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h0000_0050; exp_w[1] = 32'h0000_0005; exp_w[2] = 32'h0000_0013;
        out_ready   = 1'b0;
        trace_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            trace_pc    = {32'h0000_0009, 32'h200 + 32'(i * 4)};
            trace_instr = 32'(i);
            tick();
        end
        trace_valid = 1'b0;
        out_ready   = 1'b1;
        tick();
        vectors++;
        if (out_data !== 32'h9 || level !== 5'd5) begin
            miscompares++;
            $display("FAIL clear_setup: got data=%h level=%0d, required 00000009/5", out_data, level);
        end
        out_ready   = 1'b0;
        clear       = 1'b1;
        trace_valid = 1'b1;
        trace_pc    = 64'hFFFF;
        tick();
        clear       = 1'b0;
        trace_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || level !== 5'd0 || drop_count !== 16'd0 || full !== 1'b0 ||
            out_data !== 32'd0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_now: got valid=%b level=%0d drop=%0d full=%b data=%h last=%b, required 0/0/0/0/0/0",
                     out_valid, level, drop_count, full, out_data, out_last);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            miscompares++;
            $display("FAIL clear_discard: got valid=%b level=%0d, required 0/0", out_valid, level);
        end
        out_ready   = 1'b1;
        trace_valid = 1'b1;
        trace_pc    = 64'h0000_0005_0000_0050;
        trace_instr = 32'h0000_0013;
        tick();
        trace_valid = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exp_w[w] || out_last !== (w == 2)) begin
                miscompares++;
                $display("FAIL post_clear_w%0d: got valid=%b data=%h last=%b, required 1/%h/%b",
                         w, out_valid, out_data, out_last, exp_w[w], (w == 2));
            end
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_clear_end: got valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_record();
        out_ready   = 1'b1;
        trace_valid = 1'b1;
        trace_pc    = 64'h0000_0007_0000_0077;
        trace_instr = 32'h0000_0777;
        tick();
        trace_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_data !== 32'h7 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_setup: got valid=%b data=%h, required 1/00000007", out_valid, out_data);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_last !== 1'b0 || level !== 5'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got valid=%b data=%h last=%b level=%0d, required 0/0/0/0",
                     out_valid, out_data, out_last, level);
        end
        out_ready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || level !== 5'd0) begin
            miscompares++;
            $display("FAIL mid_release: got valid=%b data=%h level=%0d, required 0/0/0",
                     out_valid, out_data, level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_reset_mid_record();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
